// File: rtl/guess_scorer_if.sv
// Control, operand and result signals of the guess scorer, grouped for port use.
// The master side drives requests and operands; the slave side is the scorer itself.
interface guess_scorer_if;
  logic             start;
  logic             clear;
  logic [3:0][3:0]  Secret;
  logic [3:0][3:0]  Guess;
  logic [2:0]       turn_count;
  logic [2:0]       hist_rd_idx;
  logic [2:0]       Count_A;
  logic [2:0]       Count_B;
  logic             busy;
  logic             done;
  logic             result_valid;
  logic             win;
  logic [5:0]       hist_valid;
  logic [2:0]       hist_rd_A;
  logic [2:0]       hist_rd_B;

  modport master (
    output start, clear, Secret, Guess, turn_count, hist_rd_idx,
    input  Count_A, Count_B, busy, done, result_valid, win,
           hist_valid, hist_rd_A, hist_rd_B
  );

  modport slave (
    input  start, clear, Secret, Guess, turn_count, hist_rd_idx,
    output Count_A, Count_B, busy, done, result_valid, win,
           hist_valid, hist_rd_A, hist_rd_B
  );
endinterface

// File: rtl/guess_scorer.sv
// Bulls-and-cows style scorer: compares 16 guess/secret digit pairs, one per cycle,
// and keeps a six-entry per-turn history of A/B scores.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | snapshot operands, clear accumulators
// SCAN  | 16 cycles, one guess/secret digit pair per cycle
// DONE  | one-cycle completion, result and history already registered
module guess_scorer (
  input logic           clk,
  input logic           RESET,
  guess_scorer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  state_t          state;
  logic [3:0][3:0] sec_q;
  logic [3:0][3:0] gss_q;
  logic [2:0]      turn_q;
  logic [3:0]      idx;
  logic [2:0]      acc_a;
  logic [2:0]      acc_b;
  logic [2:0]      count_a_q;
  logic [2:0]      count_b_q;
  logic            busy_q;
  logic            done_q;
  logic            result_valid_q;
  logic            win_q;
  logic [5:0]      hist_valid_q;
  logic [2:0]      hist_a [0:5];
  logic [2:0]      hist_b [0:5];

  logic [3:0] g_dig;
  logic [3:0] s_dig;
  logic       hit;
  logic [2:0] acc_a_nxt;
  logic [2:0] acc_b_nxt;
  logic [2:0] rd_a;
  logic [2:0] rd_b;

  // Equal digits share the same range check, so testing one side is enough.
  always_comb begin
    g_dig     = gss_q[idx[3:2]];
    s_dig     = sec_q[idx[1:0]];
    hit       = (g_dig == s_dig) && (g_dig <= 4'd9);
    acc_a_nxt = acc_a;
    acc_b_nxt = acc_b;
    if (hit && (idx[3:2] == idx[1:0])) acc_a_nxt = acc_a + 3'd1;
    if (hit && (idx[3:2] != idx[1:0])) acc_b_nxt = acc_b + 3'd1;
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if ((bus.hist_rd_idx <= 3'd5) && hist_valid_q[bus.hist_rd_idx]) begin
      rd_a = hist_a[bus.hist_rd_idx];
      rd_b = hist_b[bus.hist_rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (RESET || bus.clear) begin
      state          <= IDLE;
      idx            <= '0;
      acc_a          <= '0;
      acc_b          <= '0;
      count_a_q      <= '0;
      count_b_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
      win_q          <= 1'b0;
      hist_valid_q   <= '0;
      for (int k = 0; k < 6; k++) begin
        hist_a[k] <= '0;
        hist_b[k] <= '0;
      end
      if (RESET) begin
        sec_q  <= '0;
        gss_q  <= '0;
        turn_q <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state          <= LOAD;
            busy_q         <= 1'b1;
            result_valid_q <= 1'b0;
            win_q          <= 1'b0;
          end
        end
        LOAD: begin
          sec_q  <= bus.Secret;
          gss_q  <= bus.Guess;
          turn_q <= bus.turn_count;
          acc_a  <= '0;
          acc_b  <= '0;
          idx    <= '0;
          state  <= SCAN;
        end
        SCAN: begin
          acc_a <= acc_a_nxt;
          acc_b <= acc_b_nxt;
          idx   <= idx + 4'd1;
          // Last pair: publish the score together with the DONE entry.
          if (idx == 4'd15) begin
            state          <= DONE;
            count_a_q      <= acc_a_nxt;
            count_b_q      <= acc_b_nxt;
            done_q         <= 1'b1;
            result_valid_q <= 1'b1;
            win_q          <= (acc_a_nxt == 3'd4);
            if (turn_q <= 3'd5) begin
              hist_a[turn_q]       <= acc_a_nxt;
              hist_b[turn_q]       <= acc_b_nxt;
              hist_valid_q[turn_q] <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Count_A      = count_a_q;
  assign bus.Count_B      = count_b_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = result_valid_q;
  assign bus.win          = win_q;
  assign bus.hist_valid   = hist_valid_q;
  assign bus.hist_rd_A    = rd_a;
  assign bus.hist_rd_B    = rd_b;

endmodule

// File: doc/guess_scorer.md
GUESS_SCORER -- requirements
Module: guess_scorer

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: RESET  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: start  input  1  one-cycle request to score the current Secret/Guess.
REQ-004 SHALL have port: clear  input  1  synchronous game-clear pulse (P3 restart).
REQ-005 SHALL have port: Secret  input  4x4 (index 0..3)  secret digits, 4'hA = blank.
REQ-006 SHALL have port: Guess  input  4x4 (index 0..3)  guess digits, 4'hA = blank.
REQ-007 SHALL have port: turn_count  input  3  current turn number, 0..5 valid.
REQ-008 SHALL have port: hist_rd_idx  input  3  history read address.
REQ-009 SHALL have port: Count_A  output  3  exact-position matches.
REQ-010 SHALL have port: Count_B  output  3  wrong-position matches.
REQ-011 SHALL have port: busy  output  1  scoring in progress.
REQ-012 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port: result_valid  output  1  Count_A/Count_B hold a finished score.
REQ-014 SHALL have port: win  output  1  last score was 4A.
REQ-015 SHALL have port: hist_valid  output  6  bit t set when turn t has a stored score.
REQ-016 SHALL have port: hist_rd_A  output  3  stored A for hist_rd_idx.
REQ-017 SHALL have port: hist_rd_B  output  3  stored B for hist_rd_idx.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, SCAN, DONE; the FSM SHALL leave IDLE only on start.
REQ-019 SHALL treat start as accepted only in IDLE; start in LOAD/SCAN/DONE SHALL be ignored, not queued.
REQ-020 SHALL follow this timeline from start sampled in cycle 0: LOAD in cycle 1, SCAN in cycles 2-17, DONE in cycle 18, IDLE in cycle 19.
REQ-021 In LOAD, SHALL snapshot Secret, Guess and turn_count into internal registers, clear the A/B accumulators, and set the pair index to 0; later input changes SHALL NOT affect the score.
REQ-022 SCAN SHALL process one pair per cycle in index order 0..15, with i = index[3:2] (guess digit) and j = index[1:0] (secret digit).
REQ-023 For each pair: if Guess[i] == Secret[j] and both digits are <= 9, SHALL increment A when i == j and B otherwise; digits > 9 SHALL never match.
REQ-024 Accumulators SHALL be 3 bits; with non-duplicate digits Count_A + Count_B <= 4, and no saturation logic SHALL be required.
REQ-025 On entry to DONE, SHALL register Count_A/Count_B from the accumulators; they SHALL hold until the next DONE, clear, or RESET.
REQ-026 done SHALL be high for exactly cycle 18.
REQ-027 busy SHALL be high in LOAD, SCAN and DONE.
REQ-028 result_valid SHALL rise with done and fall when the next start is accepted, or on clear.
REQ-029 win SHALL be set at DONE iff the registered Count_A == 4, and SHALL be cleared when the next start is accepted, or on clear.
REQ-030 In DONE, SHALL write the A/B pair to history entry [latched turn_count] and set that hist_valid bit; if latched turn_count > 5, SHALL write nothing.
REQ-031 A rewrite of an existing history entry SHALL overwrite it.
REQ-032 hist_rd_A/hist_rd_B SHALL be combinational reads of the history registers; if hist_rd_idx > 5 or the entry is not valid, SHALL return 0.
REQ-033 clear SHALL, in any state, force IDLE, abort any scan with no done pulse, and zero Count_A, Count_B, result_valid, win, hist_valid and all history.
REQ-034 If clear and start are high in the same cycle, clear SHALL take priority and start SHALL be dropped.

Reset
REQ-035 RESET SHALL have priority over clear and start, SHALL force IDLE, and SHALL zero every output and history register on the next rising edge.
REQ-036 Reset values SHALL be: Count_A=0, Count_B=0, busy=0, done=0, result_valid=0, win=0, hist_valid=6'b0, hist_rd_A=0, hist_rd_B=0.
REQ-037 An assertion of RESET during SCAN SHALL produce no done pulse and no history write.

Verification
REQ-038 SHALL check: Secret[3..0]=1,2,3,4, Guess=1,2,3,4, turn_count=0, start in cycle 0 -> done in cycle 18, Count_A=4, Count_B=0, win=1, hist_valid=6'b000001.
REQ-039 SHALL check: Secret=1,2,3,4, Guess=4,3,2,1 -> Count_A=0, Count_B=4, win=0.
REQ-040 SHALL check: Secret=5,6,7,8, Guess=5,8,0,9 -> Count_A=1, Count_B=1; and Secret all 4'hA, Guess all 4'hA -> Count_A=0, Count_B=0.
REQ-041 SHALL check: Guess changed during cycles 2-17 -> score unchanged; second start in cycle 5 ignored -> only one done, in cycle 18.
REQ-042 SHALL check: clear in cycle 10 -> no done, busy=0 in cycle 11, all history zero; clear and start together -> stays IDLE.
REQ-043 SHALL check: scores written at turn_count 0 and 2, turn_count=6 scored -> hist_valid=6'b000101; hist_rd_idx=1 or 7 -> hist_rd_A=0, hist_rd_B=0.
